// File: rtl/loopback_pkg.sv
// Shared definitions for the N-channel loopback router: mode encodings and
// the ASCII case-swap rule applied to bytes in CASESWAP mode.
package loopback_pkg;

  typedef enum logic [1:0] {
    MODE_LOOP     = 2'b00,
    MODE_ROTATE   = 2'b01,
    MODE_CASESWAP = 2'b10,
    MODE_SINK     = 2'b11
  } mode_e;

  localparam int MODE_W   = 2;
  localparam logic [7:0] CASE_BIT = 8'h20;

  // Letters A-Z / a-z toggle case; every other byte passes unchanged.
  function automatic logic [7:0] case_swap(input logic [7:0] b);
    logic is_upper;
    logic is_lower;
    is_upper = (b >= 8'h41) && (b <= 8'h5A);
    is_lower = (b >= 8'h61) && (b <= 8'h7A);
    if (is_upper || is_lower) begin
      return b ^ CASE_BIT;
    end
    return b;
  endfunction

endpackage

// File: rtl/loopback_fifo.sv
// Synchronous first-word-fall-through FIFO. Head entry is visible on rd_data
// whenever the FIFO is non-empty; rd_data reads as zero while empty so nothing
// stale or unknown ever leaves the block. A write into an empty FIFO appears
// on the output one cycle later (no bypass path).
module loopback_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic [AW:0]       level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              push;
  logic              pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign level   = cnt;
  assign pop     = rd_en && !empty;
  // At full a write is still accepted when the same cycle pops the head.
  assign push    = wr_en && (!full || pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates the output.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/loopback_nch_router.sv
// Application-side data engine for the multi-channel CDC core. Bytes from each
// OUT channel are routed into per-destination FWFT FIFOs that feed the IN
// channels: straight loopback, rotate to the next channel, case-swapped
// loopback, or discarded (sink).
//
// Mode FSM
//   state     | meaning
//   ST_ACTIVE | mode_q in effect, no drain in progress
//   ST_DRAIN  | mode_i differs from mode_q, inputs stalled, waiting for FIFOs to empty
module loopback_nch_router
  import loopback_pkg::*;
#(
  parameter int  CHANNELS   = 2,
  parameter int  DATA_W     = 8,
  parameter int  FIFO_DEPTH = 16,
  parameter int  CNT_W      = 16,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [MODE_W-1:0]            mode_i,
  input  logic [DATA_W*CHANNELS-1:0]   out_data_i,
  input  logic [CHANNELS-1:0]          out_valid_i,
  output logic [CHANNELS-1:0]          out_ready_o,
  output logic [DATA_W*CHANNELS-1:0]   in_data_o,
  output logic [CHANNELS-1:0]          in_valid_o,
  input  logic [CHANNELS-1:0]          in_ready_i,
  output logic [MODE_W-1:0]            mode_o,
  output logic [CHANNELS*(AW+1)-1:0]   level_o,
  output logic [CNT_W-1:0]             rx_count_o
);

  typedef enum logic {ST_ACTIVE, ST_DRAIN} state_e;

  state_e            state;
  mode_e             mode_q;
  logic              ready_en;
  logic              pending;
  logic              all_empty;

  logic [CHANNELS-1:0] wr_en;
  logic [DATA_W-1:0]   wr_data [CHANNELS];
  logic [DATA_W-1:0]   rd_data [CHANNELS];
  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] empty;
  logic [CHANNELS-1:0] pop;
  logic [AW:0]         level [CHANNELS];
  logic [CHANNELS-1:0] rdy;
  logic [CNT_W-1:0]    rx_q;
  logic [CNT_W-1:0]    acc_sum;

  // Destination FIFO for source channel s under mode m.
  function automatic logic [CW-1:0] dest_of(input int s, input mode_e m);
    int d;
    d = (m == MODE_ROTATE) ? ((s + 1) % CHANNELS) : s;
    return CW'(d);
  endfunction

  // Case swap touches only the low byte of wider lanes.
  function automatic logic [DATA_W-1:0] swap_word(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r      = w;
    r[7:0] = case_swap(w[7:0]);
    return r;
  endfunction

  assign pending   = (mode_i != mode_q);
  assign all_empty = &empty;
  assign pop       = in_ready_i & ~empty;

  // Per-source ready and write steering into the destination FIFOs.
  always_comb begin
    logic [CW-1:0] d;
    rdy   = '0;
    wr_en = '0;
    d     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      wr_data[k] = '0;
    end
    for (int s = 0; s < CHANNELS; s++) begin
      if (mode_q == MODE_SINK) begin
        rdy[s] = ready_en && !pending;
      end else begin
        d      = dest_of(s, mode_q);
        rdy[s] = ready_en && !pending && (!full[d] || pop[d]);
        if (out_valid_i[s] && rdy[s]) begin
          wr_en[d] = 1'b1;
          if (mode_q == MODE_CASESWAP) begin
            wr_data[d] = swap_word(out_data_i[s*DATA_W +: DATA_W]);
          end else begin
            wr_data[d] = out_data_i[s*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  assign out_ready_o = rdy;

  // Number of bytes accepted across all OUT channels this cycle.
  always_comb begin
    acc_sum = '0;
    for (int s = 0; s < CHANNELS; s++) begin
      acc_sum = acc_sum + CNT_W'(out_valid_i[s] & rdy[s]);
    end
  end

  // Mode FSM: a requested change stalls inputs and lands once all FIFOs are empty.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= ST_ACTIVE;
      mode_q   <= MODE_LOOP;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        ST_ACTIVE: begin
          if (pending) begin
            if (all_empty) begin
              mode_q <= mode_e'(mode_i);
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!pending) begin
            state <= ST_ACTIVE;
          end else if (all_empty) begin
            mode_q <= mode_e'(mode_i);
            state  <= ST_ACTIVE;
          end
        end
        default: state <= ST_ACTIVE;
      endcase
    end
  end

  // Accepted-byte counter, wraps naturally.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_q <= '0;
    end else begin
      rx_q <= rx_q + acc_sum;
    end
  end

  assign mode_o     = mode_q;
  assign rx_count_o = rx_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_fifo
    loopback_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .wr_en   (wr_en[k]),
      .wr_data (wr_data[k]),
      .full    (full[k]),
      .rd_en   (in_ready_i[k]),
      .rd_data (rd_data[k]),
      .empty   (empty[k]),
      .level   (level[k])
    );

    assign in_data_o[k*DATA_W +: DATA_W] = rd_data[k];
    assign in_valid_o[k]                 = !empty[k];
    assign level_o[k*(AW+1) +: AW+1]     = level[k];
  end

endmodule

// File: tb/tb_loopback_nch_router.sv
// Randomized bench for loopback_nch_router with a queue-level reference model.
module tb_loopback_nch_router;

  localparam int CH    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int AW    = 4;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [1:0]           mode_i;
  logic [1:0]           mode_o;
  logic [CH*DW-1:0]     out_data;
  logic [CH*DW-1:0]     in_data;
  logic [CH-1:0]        out_valid;
  logic [CH-1:0]        out_ready;
  logic [CH-1:0]        in_valid;
  logic [CH-1:0]        in_ready;
  logic [CH*(AW+1)-1:0] level;
  logic [CNT_W-1:0]     rx_count;

  always #5 clk = ~clk;

  loopback_nch_router #(
    .CHANNELS   (CH),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .mode_i      (mode_i),
    .out_data_i  (out_data),
    .out_valid_i (out_valid),
    .out_ready_o (out_ready),
    .in_data_o   (in_data),
    .in_valid_o  (in_valid),
    .in_ready_i  (in_ready),
    .mode_o      (mode_o),
    .level_o     (level),
    .rx_count_o  (rx_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model state: per-destination byte queues and the mode in effect.
  logic [7:0]     fq      [CH][$];
  logic [7:0]     tx_q    [CH][$];
  logic [7:0]     dut_log [CH][$];
  logic [7:0]     eq      [$];
  int             mq;
  bit             started;
  logic [CNT_W-1:0] rx;
  logic [CH-1:0]  er;
  logic [CH-1:0]  acc;
  bit             rnd_on;
  int             p_valid;
  int             p_rdy [CH];
  int             iv_seen;

  function automatic logic [7:0] swap_ref(input logic [7:0] b);
    if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)) return b ^ 8'h20;
    return b;
  endfunction

  function automatic int dest(input int s);
    return (mq == 1) ? (s + 1) % CH : s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      fq[k].delete();
      tx_q[k].delete();
    end
    mq        = 0;
    started   = 0;
    rx        = '0;
    er        = '0;
    acc       = '0;
    out_valid = '0;
  endtask

  task automatic clear_logs();
    for (int k = 0; k < CH; k++) dut_log[k].delete();
  endtask

  // Compare every output against the model, then log bytes the DUT hands out.
  task automatic sample_and_check();
    logic [CH-1:0]        ev;
    logic [CH*DW-1:0]     ed;
    logic [CH*(AW+1)-1:0] el;
    bit                   pend;
    pend = (int'(mode_i) != mq);
    for (int d = 0; d < CH; d++) begin
      ev[d]                = (fq[d].size() > 0);
      ed[d*DW +: DW]       = ev[d] ? fq[d][0] : 8'h00;
      el[d*(AW+1) +: AW+1] = (AW+1)'(fq[d].size());
    end
    for (int s = 0; s < CH; s++) begin
      int d;
      d     = dest(s);
      er[s] = started && !pend &&
              (mq == 3 || fq[d].size() < DEPTH || (fq[d].size() > 0 && in_ready[d]));
    end
    check_val("mode", 64'(mode_o), 64'(mq));
    check_val("out_ready", 64'(out_ready), 64'(er));
    check_val("in_valid", 64'(in_valid), 64'(ev));
    check_val("in_data", 64'(in_data), 64'(ed));
    check_val("level", 64'(level), 64'(el));
    check_val("rx_count", 64'(rx_count), 64'(rx));
    if (|in_valid) iv_seen++;
    for (int d = 0; d < CH; d++) begin
      if (in_valid[d] && in_ready[d]) dut_log[d].push_back(in_data[d*DW +: DW]);
    end
  endtask

  // Apply one clock edge to the model.
  task automatic model_update();
    bit all_empty;
    bit pend;
    logic [7:0] b;
    if (!rstn) begin
      model_reset();
      return;
    end
    pend      = (int'(mode_i) != mq);
    all_empty = 1;
    for (int d = 0; d < CH; d++) if (fq[d].size() != 0) all_empty = 0;
    acc = '0;
    for (int d = 0; d < CH; d++) begin
      if (fq[d].size() > 0 && in_ready[d]) void'(fq[d].pop_front());
    end
    for (int s = 0; s < CH; s++) begin
      if (out_valid[s] && er[s]) begin
        acc[s] = 1'b1;
        rx     = rx + 1'b1;
        if (mq != 3) begin
          b = out_data[s*DW +: DW];
          if (mq == 2) b = swap_ref(b);
          fq[dest(s)].push_back(b);
        end
      end
    end
    if (pend && all_empty) mq = int'(mode_i);
    started = 1;
  endtask

  task automatic drive_next();
    for (int s = 0; s < CH; s++) begin
      if (acc[s]) begin
        void'(tx_q[s].pop_front());
        out_valid[s] = 1'b0;
      end
      if (rnd_on && tx_q[s].size() == 0) tx_q[s].push_back(8'($urandom));
      if (!out_valid[s] && tx_q[s].size() > 0 && int'($urandom_range(99)) < p_valid) begin
        out_valid[s]          = 1'b1;
        out_data[s*DW +: DW]  = tx_q[s][0];
      end
    end
    for (int d = 0; d < CH; d++) in_ready[d] = (int'($urandom_range(99)) < p_rdy[d]);
  endtask

  task automatic tick();
    @(negedge clk);
    sample_and_check();
    @(posedge clk);
    model_update();
    #1;
    drive_next();
  endtask

  task automatic set_rdy(input int p);
    for (int d = 0; d < CH; d++) p_rdy[d] = p;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int  n;
    bit  busy;
    n    = 0;
    busy = 1;
    while (busy && n < bound) begin
      tick();
      n++;
      busy = (out_valid != '0);
      for (int k = 0; k < CH; k++) if (tx_q[k].size() != 0 || fq[k].size() != 0) busy = 1;
    end
    if (busy) check_val({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic wait_mode(input string tag, input int m, input int bound);
    int n;
    mode_i = 2'(m);
    n = 0;
    while (mq != m && n < bound) begin
      tick();
      n++;
    end
    #1;
    check_val(tag, 64'(mode_o), 64'(m));
  endtask

  task automatic wait_fill(input string tag, input int d, input int n_exp, input int bound);
    int n;
    n = 0;
    while (fq[d].size() < n_exp && n < bound) begin
      tick();
      n++;
    end
    if (fq[d].size() < n_exp) check_val({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic check_log(input string tag, input int d);
    check_val({tag, "_n"}, 64'(dut_log[d].size()), 64'(eq.size()));
    for (int i = 0; i < eq.size(); i++) begin
      if (i < dut_log[d].size()) check_val(tag, 64'(dut_log[d][i]), 64'(eq[i]));
    end
  endtask

  task automatic random_run(input int cycles);
    rnd_on  = 1;
    p_valid = $urandom_range(30, 100);
    for (int i = 0; i < cycles; i++) begin
      if (i % 40 == 0) for (int d = 0; d < CH; d++) p_rdy[d] = $urandom_range(10, 100);
      tick();
    end
    rnd_on  = 0;
    p_valid = 100;
    set_rdy(100);
    wait_idle("rnd_drain", 200);
  endtask

  initial begin
    rstn     = 1'b0;
    mode_i   = 2'b00;
    out_data = '0;
    in_ready = '0;
    rnd_on   = 0;
    p_valid  = 100;
    iv_seen  = 0;
    set_rdy(100);
    model_reset();
    repeat (2) tick();
    #1;
    check_val("rst_ready", 64'(out_ready), 64'd0);
    check_val("rst_level", 64'(level), 64'd0);
    check_val("rst_in_valid", 64'(in_valid), 64'd0);
    rstn = 1'b1;
    tick();
    #1;
    check_val("ready_rise", 64'(out_ready), 64'b111);

    // LOOP directed
    clear_logs();
    tx_q[0].push_back(8'h41);
    tx_q[0].push_back(8'h42);
    tx_q[1].push_back(8'h61);
    wait_idle("loop", 50);
    eq.delete(); eq.push_back(8'h41); eq.push_back(8'h42);
    check_log("loop_ch0", 0);
    eq.delete(); eq.push_back(8'h61);
    check_log("loop_ch1", 1);
    check_val("loop_rx", 64'(rx_count), 64'd3);
    random_run(200);

    // Revert a pending change mid-drain: mode stays LOOP, ready resumes.
    set_rdy(0);
    for (int i = 0; i < 5; i++) tx_q[0].push_back(8'(8'hA0 + i));
    wait_fill("rv_fill", 0, 5, 40);
    mode_i = 2'd1;
    repeat (3) tick();
    p_rdy[0] = 100;
    repeat (3) tick();
    mode_i   = 2'd0;
    p_rdy[0] = 0;
    #1;
    check_val("rv_ready", 64'(out_ready[0]), 64'd1);
    repeat (3) tick();
    #1;
    check_val("rv_mode", 64'(mode_o), 64'd0);
    set_rdy(100);
    wait_idle("rv_drain", 50);

    // LOOP -> ROTATE with 5 bytes queued.
    set_rdy(0);
    for (int i = 0; i < 5; i++) tx_q[0].push_back(8'(8'hB0 + i));
    wait_fill("mc_fill", 0, 5, 40);
    mode_i = 2'd1;
    #1;
    check_val("mc_ready", 64'(out_ready), 64'd0);
    repeat (3) tick();
    #1;
    check_val("mc_hold", 64'(mode_o), 64'd0);
    set_rdy(100);
    wait_mode("mc_rotate", 1, 40);

    // ROTATE directed
    clear_logs();
    tx_q[2].push_back(8'h10);
    wait_idle("rot", 50);
    eq.delete(); eq.push_back(8'h10);
    check_log("rot_ch0", 0);
    check_val("rot_ch1_n", 64'(dut_log[1].size()), 64'd0);
    check_val("rot_ch2_n", 64'(dut_log[2].size()), 64'd0);
    random_run(200);

    // CASESWAP directed
    wait_mode("to_swap", 2, 40);
    clear_logs();
    tx_q[0].push_back(8'h61);
    tx_q[0].push_back(8'h5A);
    tx_q[0].push_back(8'h31);
    tx_q[0].push_back(8'h7B);
    wait_idle("swap", 60);
    eq.delete(); eq.push_back(8'h41); eq.push_back(8'h7A); eq.push_back(8'h31); eq.push_back(8'h7B);
    check_log("swap_ch0", 0);
    random_run(200);

    // Full and backpressure on ch0.
    wait_mode("to_loop", 0, 40);
    set_rdy(0);
    for (int i = 0; i < 17; i++) tx_q[0].push_back(8'(i));
    repeat (25) tick();
    #1;
    check_val("full_level", 64'(level[AW:0]), 64'd16);
    check_val("full_ready", 64'(out_ready[0]), 64'd0);
    for (int i = 0; i < 10; i++) tx_q[0].push_back(8'(8'h40 + i));
    p_rdy[0] = 100;
    tick();
    #1;
    check_val("full_pp_ready", 64'(out_ready[0]), 64'd1);
    repeat (3) tick();
    #1;
    check_val("full_pp_level", 64'(level[AW:0]), 64'd16);
    set_rdy(100);
    wait_idle("full_drain", 100);

    // SINK: fresh counter, 300 bytes, nothing comes out.
    rstn = 1'b0;
    model_reset();
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    wait_mode("to_sink", 3, 10);
    iv_seen = 0;
    p_valid = 70;
    for (int i = 0; i < 100; i++) for (int s = 0; s < CH; s++) tx_q[s].push_back(8'($urandom));
    wait_idle("sink", 600);
    check_val("sink_rx", 64'(rx_count), 64'd300);
    check_val("sink_no_valid", 64'(iv_seen), 64'd0);
    wait_mode("leave_sink", 0, 3);

    // Async reset with FIFOs holding data.
    set_rdy(0);
    rnd_on  = 1;
    p_valid = 100;
    repeat (12) tick();
    #2;
    rstn = 1'b0;
    #1;
    check_val("arst_ready", 64'(out_ready), 64'd0);
    check_val("arst_in_valid", 64'(in_valid), 64'd0);
    check_val("arst_in_data", 64'(in_data), 64'd0);
    check_val("arst_level", 64'(level), 64'd0);
    check_val("arst_rx", 64'(rx_count), 64'd0);
    check_val("arst_mode", 64'(mode_o), 64'd0);
    rnd_on = 0;
    model_reset();
    set_rdy(100);
    repeat (2) tick();
    rstn = 1'b1;
    random_run(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
